// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache and D-cache.
// One transaction at a time, with a watchdog that aborts unacknowledged accesses.
module cache_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic              i_err,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              memory_read,
    output logic              memory_write,
    output logic [ADDR_W-1:0] memory_addr,
    output logic [DATA_W-1:0] memory_data_out,
    input  logic [DATA_W-1:0] memory_data_in,
    input  logic              mem_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_e;

    localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              i_err_q, i_err_d;
    logic              d_err_q, d_err_d;
    logic              busy_q, busy_d;

    logic any_req;
    logic pick_d;
    logic grant_we;
    logic ack_hit;
    logic tmo_hit;

    // owner/last encoding: 0 = I-cache, 1 = D-cache
    assign any_req  = i_req | d_req;
    assign pick_d   = d_req & (~i_req | ~last_q);
    assign grant_we = pick_d & d_we;
    assign ack_hit  = (state_q == ISSUE) & mem_ack;
    assign tmo_hit  = (state_q == ISSUE) & TMO_EN & (cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   if (ack_hit || tmo_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;
        busy_d    = busy_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick_d;
                    last_d  = pick_d;
                    addr_d  = pick_d ? d_addr : i_addr;
                    wdata_d = pick_d ? d_wdata : '0;
                    rd_d    = ~grant_we;
                    wr_d    = grant_we;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (ack_hit) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (rd_q && owner_q)  d_rdata_d = memory_data_in;
                    if (rd_q && !owner_q) i_rdata_d = memory_data_in;
                    d_done_d = owner_q;
                    i_done_d = ~owner_q;
                end else if (tmo_hit) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    d_done_d = owner_q;
                    i_done_d = ~owner_q;
                    d_err_d  = owner_q;
                    i_err_d  = ~owner_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                rd_d   = 1'b0;
                wr_d   = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign i_done          = i_done_q;
    assign i_err           = i_err_q;
    assign i_rdata         = i_rdata_q;
    assign d_done          = d_done_q;
    assign d_err           = d_err_q;
    assign d_rdata         = d_rdata_q;
    assign memory_read     = rd_q;
    assign memory_write    = wr_q;
    assign memory_addr     = addr_q;
    assign memory_data_out = wdata_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: scoreboard of expected completions,
// a memory responder with programmable ack delay, and directed sequences.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_done, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done, d_err;
    logic [31:0] d_rdata;
    logic        memory_read, memory_write;
    logic [31:0] memory_addr, memory_data_out;
    logic [31:0] memory_data_in = '0;
    logic        mem_ack_r = 1'b0;
    logic        stray_ack = 1'b0;
    logic        mem_ack;
    logic        busy;

    assign mem_ack = mem_ack_r | stray_ack;

    cache_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_done(i_done),
        .i_err(i_err),
        .i_rdata(i_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_done(d_done),
        .d_err(d_err),
        .d_rdata(d_rdata),
        .memory_read(memory_read),
        .memory_write(memory_write),
        .memory_addr(memory_addr),
        .memory_data_out(memory_data_out),
        .memory_data_in(memory_data_in),
        .mem_ack(mem_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          ack_at = 0;
    logic [31:0] mem_rdata = '0;
    int          scnt = 0;
    int          last_len = 0;
    int          cyc = 0;
    logic [31:0] m_i_rdata = '0;
    logic [31:0] m_d_rdata = '0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory responder plus completion monitor
    always @(negedge clk) begin
        if (memory_read || memory_write) begin
            scnt++;
            last_len = scnt;
            mem_ack_r = (ack_at != 0) && (scnt == ack_at);
            memory_data_in = mem_rdata;
        end else begin
            scnt = 0;
            mem_ack_r = 1'b0;
        end
        if (rst_n) check("excl_strobe", memory_read & memory_write, 0);
        if (i_done || d_done) begin
            if (sb.size() == 0) begin
                check("unexp_done", {i_done, d_done}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("both_done", i_done & d_done, 0);
                check("owner", d_done, e.is_d);
                check("err", d_done ? d_err : i_err, e.err);
                check("other_err", d_done ? i_err : d_err, 0);
                check("rdata", d_done ? d_rdata : i_rdata, e.rdata);
                check("strobe_len", last_len, e.cyc);
            end
        end
    end

    task automatic wait_done(output int t);
        bit seen;
        seen = 0;
        t = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (i_done || d_done) begin
                seen = 1;
                t = cyc;
            end
        end
        if (!seen) check("wait_done", i_done | d_done, 1);
    endtask

    task automatic push(input logic is_d, input logic err,
                        input logic [31:0] rd, input int c);
        exp_t e;
        e.is_d = is_d;
        e.err = err;
        e.rdata = rd;
        e.cyc = c;
        sb.push_back(e);
    endtask

    initial begin
        int t[4];
        int tt;
        repeat (2) @(negedge clk);
        check("rst_rd", memory_read, 0);
        check("rst_wr", memory_write, 0);
        check("rst_busy", busy, 0);
        check("rst_done", {i_done, d_done}, 0);
        check("rst_err", {i_err, d_err}, 0);
        check("rst_addr", memory_addr, 0);
        check("rst_wdata", memory_data_out, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention straight after reset: I, D, I, D
        i_addr = 32'h100;
        d_addr = 32'h200;
        d_we = 1'b0;
        ack_at = 1;
        mem_rdata = 32'h55AA_0001;
        for (int k = 0; k < 4; k++) push(k[0], 1'b0, 32'h55AA_0001, 1);
        m_i_rdata = 32'h55AA_0001;
        m_d_rdata = 32'h55AA_0001;
        i_req = 1'b1;
        d_req = 1'b1;
        for (int k = 0; k < 3; k++) wait_done(t[k]);
        i_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        d_req = 1'b0;
        wait_done(t[3]);
        for (int k = 1; k < 4; k++) check("spacing", t[k] - t[k-1], 3);
        @(negedge clk);

        // Single I read, ack on 2nd ISSUE cycle, req dropped mid-flight
        i_addr = 32'h0000_1000;
        ack_at = 2;
        mem_rdata = 32'hDEAD_BEEF;
        push(1'b0, 1'b0, 32'hDEAD_BEEF, 2);
        m_i_rdata = 32'hDEAD_BEEF;
        i_req = 1'b1;
        @(negedge clk);
        check("t1_rd", memory_read, 1);
        check("t1_wr", memory_write, 0);
        check("t1_addr", memory_addr, 32'h1000);
        check("t1_busy", busy, 1);
        i_req = 1'b0;
        wait_done(tt);
        check("t1_irdata", i_rdata, m_i_rdata);
        check("t1_drdata", d_rdata, m_d_rdata);
        check("t1_busy_done", busy, 1);
        @(negedge clk);
        check("t1_busy_idle", busy, 0);
        check("t1_done_pulse", i_done, 0);

        // D write with immediate ack
        d_we = 1'b1;
        d_addr = 32'h0000_2004;
        d_wdata = 32'h1234_5678;
        ack_at = 1;
        mem_rdata = 32'hFFFF_0000;
        push(1'b1, 1'b0, m_d_rdata, 1);
        d_req = 1'b1;
        @(negedge clk);
        check("t2_wr", memory_write, 1);
        check("t2_rd", memory_read, 0);
        check("t2_addr", memory_addr, 32'h2004);
        check("t2_wdata", memory_data_out, 32'h1234_5678);
        d_req = 1'b0;
        d_wdata = 32'h0;
        wait_done(tt);
        check("t2_data_held", memory_data_out, 32'h1234_5678);
        @(negedge clk);
        check("t2_drdata", d_rdata, m_d_rdata);

        // Timeout on a D read, rdata must survive
        d_we = 1'b0;
        d_addr = 32'h30;
        ack_at = 0;
        push(1'b1, 1'b1, m_d_rdata, 4);
        d_req = 1'b1;
        @(negedge clk);
        d_req = 1'b0;
        d_addr = 32'hFFFF_FFFF;
        check("t4_addr", memory_addr, 32'h30);
        wait_done(tt);
        @(negedge clk);
        check("t4_drdata", d_rdata, m_d_rdata);

        i_addr = 32'h40;
        ack_at = 3;
        mem_rdata = 32'h0BAD_F00D;
        push(1'b0, 1'b0, 32'h0BAD_F00D, 3);
        m_i_rdata = 32'h0BAD_F00D;
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        wait_done(tt);
        @(negedge clk);

        // Stray ack while idle must be ignored
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_rdata", i_rdata, m_i_rdata);

        // Reset in the middle of an I read
        i_addr = 32'h50;
        ack_at = 0;
        i_req = 1'b1;
        @(negedge clk);
        check("t5_rd", memory_read, 1);
        i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_rd", memory_read, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", {i_done, d_done}, 0);
        check("t5_rst_irdata", i_rdata, 0);
        m_i_rdata = '0;
        m_d_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h60;
        ack_at = 1;
        mem_rdata = 32'h600D_600D;
        push(1'b1, 1'b0, 32'h600D_600D, 1);
        m_d_rdata = 32'h600D_600D;
        d_req = 1'b1;
        @(negedge clk);
        check("t5_grant_rd", memory_read, 1);
        check("t5_grant_addr", memory_addr, 32'h60);
        d_req = 1'b0;
        wait_done(tt);
        @(negedge clk);

        // Ack on the same cycle the watchdog would expire
        i_addr = 32'h70;
        ack_at = 4;
        mem_rdata = 32'hA5A5_A5A5;
        push(1'b0, 1'b0, 32'hA5A5_A5A5, 4);
        m_i_rdata = 32'hA5A5_A5A5;
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        wait_done(tt);
        @(negedge clk);
        check("t6_irdata", i_rdata, m_i_rdata);
        check("t6_drdata", d_rdata, m_d_rdata);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
